apb_demux: RTL and testbench
============================

Name: apb_demux

Overview:
1-master-to-4-slave APB address decoder/splitter; the fan-out counterpart of the 2-to-1 APB arbiter. One upstream APB requester drives this block's slave port. Transfers are routed by address to one of four downstream APB master ports. Unmapped addresses complete with PSLVERR from an internal default slave, and a per-transfer watchdog aborts hung slaves with PSLVERR.

Parameters:
DW, 16, data width
AW, 16, address width
BASE0..BASE3, 'h0000/'h1000/'h2000/'h3000, region base per port
MASK0..MASK3, 'hF000 each, region mask per port
TMO, 16, watchdog limit in ACCESS wait cycles; 0 disables; width 16 bits

Ports:
CLK  in  1  clock, all logic on rising edge
RESETN  in  1  synchronous active-low reset
APBS_PSEL/PENABLE/PWRITE  in  1 each  upstream control
APBS_PADDR  in  AW  upstream address
APBS_PWDATA  in  DW  upstream write data
APBS_PRDATA  out  DW  upstream read data
APBS_PREADY  out  1  upstream ready
APBS_PSLVERR  out  1  upstream error
APBMn_PSEL/PENABLE/PWRITE  out  1 each  downstream control, n=0..3
APBMn_PADDR  out  AW  downstream address, n=0..3
APBMn_PWDATA  out  DW  downstream write data, n=0..3
APBMn_PRDATA  in  DW  downstream read data, n=0..3
APBMn_PREADY/PSLVERR  in  1 each  downstream response, n=0..3
TMO_EVT  out  1  one-cycle pulse on watchdog abort
TMO_PORT  out  2  index of last aborted port, held until next abort

Behaviour:
- Decode: hit_n = ((APBS_PADDR & MASKn) == BASEn). Lowest n wins on overlap. No hit means miss.
- FSM states: IDLE, ACCESS.
  - IDLE: when APBS_PSEL=1, latch idx and miss, clear wdog counter, go to ACCESS.
  - ACCESS: on upstream completion (APBS_PREADY=1) go to IDLE. If APBS_PSEL=0 (upstream violation) go to IDLE silently.
- Routing:
  - Setup cycle (IDLE): APBMn_PSEL = APBS_PSEL & hit_n & ~miss, driven combinationally, so no added setup latency.
  - ACCESS: APBMn_PSEL = APBS_PSEL & (idx==n) & ~miss & ~abort.
  - APBMn_PENABLE = APBMn_PSEL & APBS_PENABLE.
  - PADDR, PWDATA and PWRITE are broadcast unchanged to all ports.
- Response in ACCESS, normal case: APBS_PREADY, PSLVERR and PRDATA come combinationally from port idx. Zero added wait states.
- Miss: no downstream PSEL at any point. First ACCESS cycle returns PREADY=1, PSLVERR=1, PRDATA=0.
- Watchdog:
  - The counter increments each ACCESS cycle in which the selected PREADY=0.
  - In the ACCESS cycle where counter==TMO and PREADY=0 (abort): APBS_PREADY=1, PSLVERR=1, PRDATA=0, TMO_EVT=1, TMO_PORT<=idx, and downstream PSEL/PENABLE are deasserted that cycle.
  - Downstream PREADY arriving in the same cycle as the abort wins: normal completion, no event.
  - TMO=0: watchdog disabled.
- Back-to-back transfers: the completion cycle returns to IDLE. The next upstream setup is decoded on the following cycle, with no idle gap required.
- Outside ACCESS: APBS_PREADY=0, APBS_PSLVERR=0, APBS_PRDATA=0.
- Reset (RESETN=0 at a clock edge):
  - State goes to IDLE; counter, idx, TMO_EVT and TMO_PORT are cleared.
  - While RESETN=0, all APBMn_PSEL/PENABLE and APBS_PREADY/PSLVERR are forced to 0.
  - Reset mid-transfer abandons the transfer with no response.

Test Plan:
1. Write 'h2004 data 'hBEEF, port 2 PREADY immediate -> APBM2 PSEL in setup cycle, PENABLE next cycle, PWDATA='hBEEF; no other port selected; APBS_PREADY=1 in cycle 2; PSLVERR=0.
2. Read 'h1010, port 1 inserts 3 wait states, PRDATA='h5A5A -> APBS_PREADY low for 3 ACCESS cycles, then 1 with PRDATA='h5A5A; total 5 cycles setup to completion.
3. Read 'h8000 (miss) -> no APBMn_PSEL ever high; ACCESS cycle returns PREADY=1, PSLVERR=1, PRDATA=0.
4. Port 3 PREADY stuck 0, TMO=16, read 'h3000 -> 16 wait cycles, then 17th ACCESS cycle PREADY=1, PSLVERR=1, TMO_EVT pulses once, TMO_PORT=3, APBM3_PSEL drops that cycle. Repeat with PREADY rising exactly on that cycle -> normal completion, no TMO_EVT.
5. Back-to-back write 'h0000 then read 'h1000 -> port 0 completes, next cycle APBM1_PSEL setup, no overlap of PSELs.
6. RESETN low during port 0 ACCESS wait -> next cycle all PSEL/PENABLE/PREADY 0, TMO_PORT=0. After release, a transfer to 'h2000 completes normally.

Source files
------------

// File: rtl/apb_demux.sv
// apb_demux: one APB requester fanned out to four APB completers by address.
// Unmapped addresses are answered with an error by an internal default slave;
// a per-transfer watchdog aborts a completer that never raises PREADY.
module apb_demux #(
  parameter int unsigned   DW    = 16,
  parameter int unsigned   AW    = 16,
  parameter logic [AW-1:0] BASE0 = 16'h0000,
  parameter logic [AW-1:0] BASE1 = 16'h1000,
  parameter logic [AW-1:0] BASE2 = 16'h2000,
  parameter logic [AW-1:0] BASE3 = 16'h3000,
  parameter logic [AW-1:0] MASK0 = 16'hF000,
  parameter logic [AW-1:0] MASK1 = 16'hF000,
  parameter logic [AW-1:0] MASK2 = 16'hF000,
  parameter logic [AW-1:0] MASK3 = 16'hF000,
  parameter logic [15:0]   TMO   = 16'd16
) (
  input  logic          CLK,
  input  logic          RESETN,
  // upstream slave port
  input  logic          APBS_PSEL,
  input  logic          APBS_PENABLE,
  input  logic          APBS_PWRITE,
  input  logic [AW-1:0] APBS_PADDR,
  input  logic [DW-1:0] APBS_PWDATA,
  output logic [DW-1:0] APBS_PRDATA,
  output logic          APBS_PREADY,
  output logic          APBS_PSLVERR,
  // downstream master port 0
  output logic          APBM0_PSEL,
  output logic          APBM0_PENABLE,
  output logic          APBM0_PWRITE,
  output logic [AW-1:0] APBM0_PADDR,
  output logic [DW-1:0] APBM0_PWDATA,
  input  logic [DW-1:0] APBM0_PRDATA,
  input  logic          APBM0_PREADY,
  input  logic          APBM0_PSLVERR,
  // downstream master port 1
  output logic          APBM1_PSEL,
  output logic          APBM1_PENABLE,
  output logic          APBM1_PWRITE,
  output logic [AW-1:0] APBM1_PADDR,
  output logic [DW-1:0] APBM1_PWDATA,
  input  logic [DW-1:0] APBM1_PRDATA,
  input  logic          APBM1_PREADY,
  input  logic          APBM1_PSLVERR,
  // downstream master port 2
  output logic          APBM2_PSEL,
  output logic          APBM2_PENABLE,
  output logic          APBM2_PWRITE,
  output logic [AW-1:0] APBM2_PADDR,
  output logic [DW-1:0] APBM2_PWDATA,
  input  logic [DW-1:0] APBM2_PRDATA,
  input  logic          APBM2_PREADY,
  input  logic          APBM2_PSLVERR,
  // downstream master port 3
  output logic          APBM3_PSEL,
  output logic          APBM3_PENABLE,
  output logic          APBM3_PWRITE,
  output logic [AW-1:0] APBM3_PADDR,
  output logic [DW-1:0] APBM3_PWDATA,
  input  logic [DW-1:0] APBM3_PRDATA,
  input  logic          APBM3_PREADY,
  input  logic          APBM3_PSLVERR,
  // watchdog reporting
  output logic          TMO_EVT,
  output logic [1:0]    TMO_PORT
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  // Address falls inside a region when its masked bits equal the region base.
  function automatic logic region_hit(input logic [AW-1:0] addr,
                                      input logic [AW-1:0] base,
                                      input logic [AW-1:0] mask);
    region_hit = ((addr & mask) == base);
  endfunction

  state_t          state_r;
  state_t          state_nxt_s;
  logic [1:0]      idx_r;
  logic            miss_r;
  logic [15:0]     wdog_r;
  logic [1:0]      tmo_port_r;

  logic [3:0]      hit_s;
  logic [1:0]      dec_idx_s;
  logic            dec_miss_s;
  logic [DW-1:0]   sel_prdata_s;
  logic            sel_pready_s;
  logic            sel_pslverr_s;
  logic            abort_s;
  logic            tmo_en_s;
  logic [3:0]      m_psel_s;
  logic [3:0]      m_penable_s;
  logic [DW-1:0]   apbs_prdata_s;
  logic            apbs_pready_s;
  logic            apbs_pslverr_s;

  assign tmo_en_s = (TMO != 16'd0);

  // Region match of the live upstream address against all four windows.
  always_comb begin
    hit_s    = 4'b0000;
    hit_s[0] = region_hit(APBS_PADDR, BASE0, MASK0);
    hit_s[1] = region_hit(APBS_PADDR, BASE1, MASK1);
    hit_s[2] = region_hit(APBS_PADDR, BASE2, MASK2);
    hit_s[3] = region_hit(APBS_PADDR, BASE3, MASK3);
  end

  // Priority encode the hits: the lowest port wins when regions overlap.
  always_comb begin
    dec_idx_s  = 2'd0;
    dec_miss_s = 1'b0;
    if (hit_s[0]) begin
      dec_idx_s = 2'd0;
    end else if (hit_s[1]) begin
      dec_idx_s = 2'd1;
    end else if (hit_s[2]) begin
      dec_idx_s = 2'd2;
    end else if (hit_s[3]) begin
      dec_idx_s = 2'd3;
    end else begin
      dec_miss_s = 1'b1;
    end
  end

  // Response of the port latched for the current transfer.
  always_comb begin
    sel_prdata_s  = {DW{1'b0}};
    sel_pready_s  = 1'b0;
    sel_pslverr_s = 1'b0;
    case (idx_r)
      2'd0: begin
        sel_prdata_s  = APBM0_PRDATA;
        sel_pready_s  = APBM0_PREADY;
        sel_pslverr_s = APBM0_PSLVERR;
      end
      2'd1: begin
        sel_prdata_s  = APBM1_PRDATA;
        sel_pready_s  = APBM1_PREADY;
        sel_pslverr_s = APBM1_PSLVERR;
      end
      2'd2: begin
        sel_prdata_s  = APBM2_PRDATA;
        sel_pready_s  = APBM2_PREADY;
        sel_pslverr_s = APBM2_PSLVERR;
      end
      2'd3: begin
        sel_prdata_s  = APBM3_PRDATA;
        sel_pready_s  = APBM3_PREADY;
        sel_pslverr_s = APBM3_PSLVERR;
      end
      default: begin
        sel_prdata_s  = {DW{1'b0}};
        sel_pready_s  = 1'b0;
        sel_pslverr_s = 1'b0;
      end
    endcase
  end

  // Watchdog abort: limit reached on a mapped access and the completer is still not ready.
  // A PREADY arriving in the same cycle takes precedence over the abort.
  always_comb begin
    abort_s = 1'b0;
    if (RESETN && (state_r == ST_ACCESS) && APBS_PSEL && !miss_r && tmo_en_s &&
        (wdog_r == TMO) && !sel_pready_s) begin
      abort_s = 1'b1;
    end else begin
      abort_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: enter ACCESS after a setup cycle, leave on completion or a dropped PSEL.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (APBS_PSEL) begin
          state_nxt_s = ST_ACCESS;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (!APBS_PSEL) begin
          state_nxt_s = ST_IDLE;
        end else if (apbs_pready_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ACCESS;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Upstream response: from the latched port, the default slave on a miss, or the watchdog.
  always_comb begin
    apbs_prdata_s  = {DW{1'b0}};
    apbs_pready_s  = 1'b0;
    apbs_pslverr_s = 1'b0;
    if (RESETN && (state_r == ST_ACCESS) && APBS_PSEL) begin
      if (miss_r || abort_s) begin
        apbs_prdata_s  = {DW{1'b0}};
        apbs_pready_s  = 1'b1;
        apbs_pslverr_s = 1'b1;
      end else begin
        apbs_prdata_s  = sel_prdata_s;
        apbs_pready_s  = sel_pready_s;
        apbs_pslverr_s = sel_pslverr_s;
      end
    end else begin
      apbs_prdata_s  = {DW{1'b0}};
      apbs_pready_s  = 1'b0;
      apbs_pslverr_s = 1'b0;
    end
  end

  // Downstream selects: live decode during setup, latched port during access.
  always_comb begin
    m_psel_s = 4'b0000;
    for (int n = 0; n < 4; n++) begin
      if (!RESETN) begin
        m_psel_s[n] = 1'b0;
      end else if (state_r == ST_IDLE) begin
        m_psel_s[n] = APBS_PSEL & (dec_idx_s == 2'(n)) & ~dec_miss_s;
      end else begin
        m_psel_s[n] = APBS_PSEL & (idx_r == 2'(n)) & ~miss_r & ~abort_s;
      end
    end
  end

  // Downstream enables follow the upstream enable on the selected port only.
  always_comb begin
    m_penable_s = 4'b0000;
    for (int n = 0; n < 4; n++) begin
      m_penable_s[n] = m_psel_s[n] & APBS_PENABLE;
    end
  end

  // Transfer context and watchdog: latch the target at setup, count stalled access cycles.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      idx_r      <= 2'd0;
      miss_r     <= 1'b0;
      wdog_r     <= 16'd0;
      tmo_port_r <= 2'd0;
    end else begin
      if ((state_r == ST_IDLE) && APBS_PSEL) begin
        idx_r  <= dec_idx_s;
        miss_r <= dec_miss_s;
        wdog_r <= 16'd0;
      end else if ((state_r == ST_ACCESS) && APBS_PSEL && !miss_r && !sel_pready_s &&
                   (wdog_r != 16'hFFFF)) begin
        wdog_r <= wdog_r + 16'd1;
      end else begin
        wdog_r <= wdog_r;
      end
      if (abort_s) begin
        tmo_port_r <= idx_r;
      end else begin
        tmo_port_r <= tmo_port_r;
      end
    end
  end

  assign APBS_PRDATA  = apbs_prdata_s;
  assign APBS_PREADY  = apbs_pready_s;
  assign APBS_PSLVERR = apbs_pslverr_s;

  assign TMO_EVT  = abort_s;
  assign TMO_PORT = tmo_port_r;

  assign APBM0_PSEL    = m_psel_s[0];
  assign APBM1_PSEL    = m_psel_s[1];
  assign APBM2_PSEL    = m_psel_s[2];
  assign APBM3_PSEL    = m_psel_s[3];
  assign APBM0_PENABLE = m_penable_s[0];
  assign APBM1_PENABLE = m_penable_s[1];
  assign APBM2_PENABLE = m_penable_s[2];
  assign APBM3_PENABLE = m_penable_s[3];

  // Address, write data and direction are broadcast to every port.
  assign APBM0_PWRITE = APBS_PWRITE;
  assign APBM1_PWRITE = APBS_PWRITE;
  assign APBM2_PWRITE = APBS_PWRITE;
  assign APBM3_PWRITE = APBS_PWRITE;
  assign APBM0_PADDR  = APBS_PADDR;
  assign APBM1_PADDR  = APBS_PADDR;
  assign APBM2_PADDR  = APBS_PADDR;
  assign APBM3_PADDR  = APBS_PADDR;
  assign APBM0_PWDATA = APBS_PWDATA;
  assign APBM1_PWDATA = APBS_PWDATA;
  assign APBM2_PWDATA = APBS_PWDATA;
  assign APBM3_PWDATA = APBS_PWDATA;

endmodule

// File: tb/tb_apb_demux.sv
// Directed bench for apb_demux: expected upstream responses are queued by the
// stimulus and checked by a separate monitor; routing and watchdog details are
// checked inline.
module tb_apb_demux;

  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic        s_psel = 1'b0;
  logic        s_penable = 1'b0;
  logic        s_pwrite = 1'b0;
  logic [15:0] s_paddr = 16'h0000;
  logic [15:0] s_pwdata = 16'h0000;
  wire  [15:0] s_prdata;
  wire         s_pready;
  wire         s_pslverr;

  wire  [3:0]  m_psel;
  wire  [3:0]  m_penable;
  wire  [3:0]  m_pwrite;
  wire  [15:0] m_paddr [4];
  wire  [15:0] m_pwdata [4];
  logic [15:0] m_prdata [4];
  logic        m_pready [4];
  logic        m_pslverr [4];
  wire         tmo_evt;
  wire  [1:0]  tmo_port;

  // completer models
  logic [15:0] sl_rdata [4];
  int          sl_wait [4];
  bit          sl_stuck [4];
  int          sl_cnt [4];

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          waits;
    bit          chk_data;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int evt_cnt = 0;
  int mon_wait = 0;

  always #5 CLK = ~CLK;

  apb_demux dut (
    .CLK(CLK), .RESETN(RESETN),
    .APBS_PSEL(s_psel), .APBS_PENABLE(s_penable), .APBS_PWRITE(s_pwrite),
    .APBS_PADDR(s_paddr), .APBS_PWDATA(s_pwdata), .APBS_PRDATA(s_prdata),
    .APBS_PREADY(s_pready), .APBS_PSLVERR(s_pslverr),
    .APBM0_PSEL(m_psel[0]), .APBM0_PENABLE(m_penable[0]), .APBM0_PWRITE(m_pwrite[0]),
    .APBM0_PADDR(m_paddr[0]), .APBM0_PWDATA(m_pwdata[0]), .APBM0_PRDATA(m_prdata[0]),
    .APBM0_PREADY(m_pready[0]), .APBM0_PSLVERR(m_pslverr[0]),
    .APBM1_PSEL(m_psel[1]), .APBM1_PENABLE(m_penable[1]), .APBM1_PWRITE(m_pwrite[1]),
    .APBM1_PADDR(m_paddr[1]), .APBM1_PWDATA(m_pwdata[1]), .APBM1_PRDATA(m_prdata[1]),
    .APBM1_PREADY(m_pready[1]), .APBM1_PSLVERR(m_pslverr[1]),
    .APBM2_PSEL(m_psel[2]), .APBM2_PENABLE(m_penable[2]), .APBM2_PWRITE(m_pwrite[2]),
    .APBM2_PADDR(m_paddr[2]), .APBM2_PWDATA(m_pwdata[2]), .APBM2_PRDATA(m_prdata[2]),
    .APBM2_PREADY(m_pready[2]), .APBM2_PSLVERR(m_pslverr[2]),
    .APBM3_PSEL(m_psel[3]), .APBM3_PENABLE(m_penable[3]), .APBM3_PWRITE(m_pwrite[3]),
    .APBM3_PADDR(m_paddr[3]), .APBM3_PWDATA(m_pwdata[3]), .APBM3_PRDATA(m_prdata[3]),
    .APBM3_PREADY(m_pready[3]), .APBM3_PSLVERR(m_pslverr[3]),
    .TMO_EVT(tmo_evt), .TMO_PORT(tmo_port)
  );

  // Completer response: ready after sl_wait stalled access cycles unless stuck.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      m_pready[n]  = !sl_stuck[n] && (sl_cnt[n] == sl_wait[n]);
      m_prdata[n]  = sl_rdata[n];
      m_pslverr[n] = 1'b0;
    end
  end

  // Completer wait-state counters.
  always @(posedge CLK) begin
    for (int n = 0; n < 4; n++) begin
      if (m_psel[n] && m_penable[n] && !m_pready[n]) sl_cnt[n] <= sl_cnt[n] + 1;
      else sl_cnt[n] <= 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", nm, act, exp);
    end
  endtask

  // Monitor: count stalled access cycles and score each upstream completion.
  always @(negedge CLK) begin
    if (tmo_evt) evt_cnt++;
    if (!RESETN) begin
      mon_wait = 0;
    end else if (s_psel && s_penable) begin
      if (!s_pready) begin
        mon_wait++;
      end else begin
        if (exp_q.size() == 0) begin
          chk("unexpected_completion", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("resp_pslverr", {31'd0, s_pslverr}, {31'd0, e.err});
          chk("resp_waits", mon_wait, e.waits);
          if (e.chk_data) chk("resp_prdata", {16'd0, s_prdata}, {16'd0, e.rdata});
        end
        mon_wait = 0;
      end
    end
  end

  task automatic push_exp(input logic [15:0] rd, input logic er, input int w, input bit cd);
    exp_t e;
    e.rdata = rd; e.err = er; e.waits = w; e.chk_data = cd;
    exp_q.push_back(e);
  endtask

  task automatic setup(input logic [15:0] a, input logic w, input logic [15:0] wd);
    @(posedge CLK); #1;
    s_psel = 1'b1; s_penable = 1'b0; s_paddr = a; s_pwrite = w; s_pwdata = wd;
  endtask

  task automatic enable();
    @(posedge CLK); #1;
    s_penable = 1'b1;
  endtask

  task automatic idle();
    @(posedge CLK); #1;
    s_psel = 1'b0; s_penable = 1'b0;
  endtask

  // Wait (bounded) for upstream PREADY; returns the number of access cycles seen.
  task automatic wait_done(input string nm, output int cyc);
    cyc = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge CLK);
      cyc++;
      if (s_pready) break;
    end
    if (!s_pready) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    int evt_base;
    for (int n = 0; n < 4; n++) begin
      sl_rdata[n] = 16'h0000; sl_wait[n] = 0; sl_stuck[n] = 1'b0;
    end

    // reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_psel", {28'd0, m_psel}, 32'h0);
    chk("rst_pready", {31'd0, s_pready}, 32'h0);
    chk("rst_tmo_evt", {31'd0, tmo_evt}, 32'h0);
    chk("rst_tmo_port", {30'd0, tmo_port}, 32'h0);
    @(posedge CLK); #1; RESETN = 1'b1;

    // 1: write 0x2004, immediate ready on port 2
    push_exp(16'h0000, 1'b0, 0, 1'b0);
    setup(16'h2004, 1'b1, 16'hBEEF);
    @(negedge CLK);
    chk("t1_setup_psel", {28'd0, m_psel}, 32'h4);
    chk("t1_setup_penable", {28'd0, m_penable}, 32'h0);
    chk("t1_pwdata", {16'd0, m_pwdata[2]}, 32'hBEEF);
    chk("t1_pwrite", {31'd0, m_pwrite[2]}, 32'h1);
    chk("t1_setup_pready", {31'd0, s_pready}, 32'h0);
    enable();
    @(negedge CLK);
    chk("t1_access_psel", {28'd0, m_psel}, 32'h4);
    chk("t1_access_penable", {28'd0, m_penable}, 32'h4);
    chk("t1_pready", {31'd0, s_pready}, 32'h1);
    idle();

    // 2: read 0x1010, three wait states on port 1
    sl_wait[1] = 3; sl_rdata[1] = 16'h5A5A;
    push_exp(16'h5A5A, 1'b0, 3, 1'b1);
    setup(16'h1010, 1'b0, 16'h0000);
    enable();
    wait_done("t2", cyc);
    chk("t2_access_cycles", cyc, 4);
    idle();

    // 3: unmapped read 0x8000
    push_exp(16'h0000, 1'b1, 0, 1'b1);
    setup(16'h8000, 1'b0, 16'h0000);
    @(negedge CLK);
    chk("t3_setup_psel", {28'd0, m_psel}, 32'h0);
    enable();
    wait_done("t3", cyc);
    chk("t3_access_cycles", cyc, 1);
    chk("t3_access_psel", {28'd0, m_psel}, 32'h0);
    idle();

    // 4a: port 3 stuck, watchdog abort on the 17th access cycle
    sl_stuck[3] = 1'b1;
    evt_base = evt_cnt;
    push_exp(16'h0000, 1'b1, 16, 1'b1);
    setup(16'h3000, 1'b0, 16'h0000);
    enable();
    wait_done("t4a", cyc);
    chk("t4a_access_cycles", cyc, 17);
    chk("t4a_tmo_evt", {31'd0, tmo_evt}, 32'h1);
    chk("t4a_abort_psel", {28'd0, m_psel}, 32'h0);
    chk("t4a_abort_penable", {28'd0, m_penable}, 32'h0);
    idle();
    @(negedge CLK);
    chk("t4a_tmo_port", {30'd0, tmo_port}, 32'h3);
    chk("t4a_evt_count", evt_cnt - evt_base, 1);
    chk("t4a_evt_after", {31'd0, tmo_evt}, 32'h0);

    // 4b: ready arrives exactly on the abort cycle -> normal completion
    sl_stuck[3] = 1'b0; sl_wait[3] = 16; sl_rdata[3] = 16'h3333;
    evt_base = evt_cnt;
    push_exp(16'h3333, 1'b0, 16, 1'b1);
    setup(16'h3000, 1'b0, 16'h0000);
    enable();
    wait_done("t4b", cyc);
    chk("t4b_access_cycles", cyc, 17);
    chk("t4b_tmo_evt", {31'd0, tmo_evt}, 32'h0);
    chk("t4b_psel", {28'd0, m_psel}, 32'h8);
    idle();
    @(negedge CLK);
    chk("t4b_evt_count", evt_cnt - evt_base, 0);
    chk("t4b_tmo_port", {30'd0, tmo_port}, 32'h3);

    // 5: back-to-back write 0x0000 then read 0x1000
    sl_wait[0] = 0; sl_wait[1] = 0; sl_rdata[1] = 16'h1111;
    push_exp(16'h0000, 1'b0, 0, 1'b0);
    push_exp(16'h1111, 1'b0, 0, 1'b1);
    setup(16'h0000, 1'b1, 16'h0F0F);
    enable();
    wait_done("t5a", cyc);
    chk("t5a_access_cycles", cyc, 1);
    chk("t5a_psel", {28'd0, m_psel}, 32'h1);
    setup(16'h1000, 1'b0, 16'h0000);
    @(negedge CLK);
    chk("t5b_setup_psel", {28'd0, m_psel}, 32'h2);
    chk("t5b_setup_penable", {28'd0, m_penable}, 32'h0);
    enable();
    wait_done("t5b", cyc);
    chk("t5b_access_cycles", cyc, 1);
    idle();

    // 6: reset during a port 0 wait, then a clean transfer to port 2
    sl_wait[0] = 5;
    setup(16'h0000, 1'b0, 16'h0000);
    enable();
    @(negedge CLK);
    chk("t6_wait_pready", {31'd0, s_pready}, 32'h0);
    @(posedge CLK); #1; RESETN = 1'b0;
    @(negedge CLK);
    chk("t6_rst_psel", {28'd0, m_psel}, 32'h0);
    chk("t6_rst_penable", {28'd0, m_penable}, 32'h0);
    chk("t6_rst_pready", {31'd0, s_pready}, 32'h0);
    @(posedge CLK); #1; s_psel = 1'b0; s_penable = 1'b0;
    @(negedge CLK);
    chk("t6_rst_tmo_port", {30'd0, tmo_port}, 32'h0);
    @(posedge CLK); #1; RESETN = 1'b1;
    sl_wait[2] = 0; sl_rdata[2] = 16'h2222;
    push_exp(16'h2222, 1'b0, 0, 1'b1);
    setup(16'h2000, 1'b0, 16'h0000);
    @(negedge CLK);
    chk("t6_post_setup_psel", {28'd0, m_psel}, 32'h4);
    enable();
    wait_done("t6", cyc);
    chk("t6_access_cycles", cyc, 1);
    idle();

    repeat (2) @(posedge CLK);
    chk("pending_expectations", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
